// File: rtl/ex_muldiv_pkg.sv
// Shared opcodes, FSM state encoding and operand-signedness helpers for the
// iterative rv64IM multiply/divide unit.
package ex_muldiv_pkg;

    localparam logic [3:0] MD_MUL    = 4'd0;
    localparam logic [3:0] MD_MULH   = 4'd1;
    localparam logic [3:0] MD_MULHSU = 4'd2;
    localparam logic [3:0] MD_MULHU  = 4'd3;
    localparam logic [3:0] MD_DIV    = 4'd4;
    localparam logic [3:0] MD_DIVU   = 4'd5;
    localparam logic [3:0] MD_REM    = 4'd6;
    localparam logic [3:0] MD_REMU   = 4'd7;
    localparam logic [3:0] MD_MULW   = 4'd8;
    localparam logic [3:0] MD_DIVW   = 4'd12;
    localparam logic [3:0] MD_DIVUW  = 4'd13;
    localparam logic [3:0] MD_REMW   = 4'd14;
    localparam logic [3:0] MD_REMUW  = 4'd15;

    typedef enum logic [2:0] {
        MdIdle = 3'd0,
        MdMul  = 3'd1,
        MdDiv  = 3'd2,
        MdFix  = 3'd3,
        MdDone = 3'd4
    } md_state_e;

    // Helpers take the base opcode (W bit cleared).
    function automatic logic op_signed_a(input logic [3:0] base);
        return base inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic op_signed_b(input logic [3:0] base);
        return base inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/ex_muldiv_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor
// if it fits, and report the resulting quotient bit.
module ex_muldiv_div_step #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    always_comb begin
        trial   = {rem_i, bit_i};
        diff    = trial - {1'b0, divisor_i};
        q_bit_o = ~diff[XLEN];
        rem_o   = q_bit_o ? diff[XLEN-1:0] : trial[XLEN-1:0];
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RISC-V M-extension unit: shift-add multiplier and restoring divider
// on operand magnitudes, with a one-cycle sign-fix stage before the result.
// Optional MULDIV_EARLY_OUT_EN: div-by-zero, signed overflow and a zero
// multiplicand complete straight from IDLE to DONE.
module ex_muldiv #(
    parameter int unsigned XLEN  = 64,
    parameter bit          W_OPS = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] srcA_i,
    input  logic [XLEN-1:0] srcB_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_req_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);
    import ex_muldiv_pkg::*;

    localparam bit          WEn  = W_OPS && (XLEN == 64);
    localparam int unsigned CntW = $clog2(XLEN);

    md_state_e          state_q;
    logic [3:0]         base_q;
    logic               w_q;
    logic               sa_q;
    logic               neg_q;
    logic               dz_q;
    logic [4:0]         rd_q;
    logic [XLEN-1:0]    a_q;
    logic [XLEN-1:0]    b_q;
    logic [2*XLEN-1:0]  prod_q;
    logic [XLEN-1:0]    quot_q;
    logic [XLEN-1:0]    rem_q;
    logic [CntW-1:0]    cnt_q;

    // Operand preparation for the accept edge.
    logic [3:0]      in_base;
    logic            in_w, in_sa, in_sb, in_div, in_rem, in_dz, in_ovf, early_out;
    logic [XLEN-1:0] a_w, b_w, mag_a, mag_b, min_mag, early_res;

    always_comb begin
        in_base = {1'b0, op_i[2:0]};
        in_w    = WEn && op_i[3];
        in_div  = in_base inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
        in_rem  = in_base inside {MD_REM, MD_REMU};
        a_w     = srcA_i;
        b_w     = srcB_i;
        if (in_w) begin
            a_w = op_signed_a(in_base) ? XLEN'($signed(srcA_i[31:0])) : XLEN'(srcA_i[31:0]);
            b_w = op_signed_b(in_base) ? XLEN'($signed(srcB_i[31:0])) : XLEN'(srcB_i[31:0]);
        end
        in_sa   = op_signed_a(in_base) && a_w[XLEN-1];
        in_sb   = op_signed_b(in_base) && b_w[XLEN-1];
        mag_a   = in_sa ? -a_w : a_w;
        mag_b   = in_sb ? -b_w : b_w;
        min_mag = in_w ? (XLEN'(1) << 31) : (XLEN'(1) << (XLEN - 1));
        in_dz   = in_div && (b_w == '0);
        in_ovf  = in_div && in_sa && in_sb && (mag_a == min_mag) && (mag_b == XLEN'(1));

        early_res = '0;
        if (in_dz) begin
            early_res = in_rem ? (in_w ? XLEN'($signed(srcA_i[31:0])) : srcA_i) : '1;
        end else if (in_ovf) begin
            early_res = in_rem ? '0 : a_w;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = in_dz || in_ovf || (!in_div && (mag_a == '0));
`else
    assign early_out = 1'b0;
`endif

    // Multiplier step: conditionally add the multiplicand into the top half, shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, prod_q[XLEN-1:1]};
    end

    logic [XLEN-1:0] step_rem;
    logic            step_q;

    ex_muldiv_div_step #(
        .XLEN(XLEN)
    ) u_div_step (
        .rem_i    (rem_q),
        .bit_i    (quot_q[XLEN-1]),
        .divisor_i(b_q),
        .rem_o    (step_rem),
        .q_bit_o  (step_q)
    );

    // Sign correction and result selection.
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, div_res, fix_res;

    always_comb begin
        prod_s  = neg_q ? -prod_q : prod_q;
        quo_s   = dz_q ? '1 : (neg_q ? -quot_q : quot_q);
        rem_s   = sa_q ? -rem_q : rem_q;
        div_res = (base_q inside {MD_REM, MD_REMU}) ? rem_s : quo_s;
        if (base_q[2]) begin
            fix_res = w_q ? XLEN'($signed(div_res[31:0])) : div_res;
        end else if (w_q) begin
            // After 32 steps the low product word sits just below the register midpoint.
            fix_res = XLEN'($signed(prod_q[XLEN-1 -: 32]));
        end else if (base_q == MD_MUL) begin
            fix_res = prod_s[XLEN-1:0];
        end else begin
            fix_res = prod_s[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        stall_req_o = ((state_q == MdIdle) && valid_i && !flush_i) ||
                      (state_q inside {MdMul, MdDiv, MdFix});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= MdIdle;
            base_q   <= '0;
            w_q      <= 1'b0;
            sa_q     <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                MdIdle: begin
                    if (valid_i && !flush_i) begin
                        base_q <= in_base;
                        w_q    <= in_w;
                        sa_q   <= in_sa;
                        neg_q  <= in_sa ^ in_sb;
                        dz_q   <= in_dz;
                        rd_q   <= rd_i;
                        a_q    <= mag_a;
                        b_q    <= mag_b;
                        cnt_q  <= in_w ? CntW'(31) : CntW'(XLEN - 1);
                        if (early_out) begin
                            state_q  <= MdDone;
                            done_o   <= 1'b1;
                            result_o <= early_res;
                            rd_o     <= rd_i;
                        end else if (in_div) begin
                            state_q <= MdDiv;
                            // W dividends are left-aligned so the step always reads the MSB.
                            quot_q  <= in_w ? (mag_a << (XLEN - 32)) : mag_a;
                            rem_q   <= '0;
                        end else begin
                            state_q <= MdMul;
                            prod_q  <= {{XLEN{1'b0}}, mag_b};
                        end
                    end
                end
                MdMul: begin
                    if (flush_i) begin
                        state_q <= MdIdle;
                    end else begin
                        prod_q <= mul_next;
                        cnt_q  <= cnt_q - CntW'(1);
                        if (cnt_q == '0) state_q <= MdFix;
                    end
                end
                MdDiv: begin
                    if (flush_i) begin
                        state_q <= MdIdle;
                    end else begin
                        quot_q <= {quot_q[XLEN-2:0], step_q};
                        rem_q  <= step_rem;
                        cnt_q  <= cnt_q - CntW'(1);
                        if (cnt_q == '0) state_q <= MdFix;
                    end
                end
                MdFix: begin
                    if (flush_i) begin
                        state_q <= MdIdle;
                    end else begin
                        state_q  <= MdDone;
                        done_o   <= 1'b1;
                        result_o <= fix_res;
                        rd_o     <= rd_q;
                    end
                end
                MdDone: state_q <= MdIdle;
                default: state_q <= MdIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed vectors push expected results, a
// monitor pops and compares on every done_o pulse.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    logic        clock, reset, valid_i, flush_i;
    logic [3:0]  op_i;
    logic [63:0] srcA_i, srcB_i;
    logic [4:0]  rd_i;
    logic        stall_req_o, done_o;
    logic [63:0] result_o;
    logic [4:0]  rd_o;

    ex_muldiv #(
        .XLEN (64),
        .W_OPS(1'b1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .valid_i    (valid_i),
        .op_i       (op_i),
        .srcA_i     (srcA_i),
        .srcB_i     (srcB_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .stall_req_o(stall_req_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_o       (rd_o)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic [4:0]  rd;
        int          n;
        bit          early;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t  sb[$];
    vec_t  vecs[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    string cur = "reset";

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s [%s]: got 0x%016h, required 0x%016h", name, cur, act, req);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (!reset && done_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_done [%s]: done_o=1 at cycle %0d, required none", cur, cyc);
            end else begin
                e = sb.pop_front();
                check("result", result_o, e.res);
                check("rd", 64'(rd_o), 64'(e.rd));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic run_op(input vec_t v);
        int lat;
        int stall_hi;
        bit got;
        @(posedge clock);
        #1;
        cur     = v.name;
        valid_i = 1'b1;
        op_i    = v.op;
        srcA_i  = v.a;
        srcB_i  = v.b;
        rd_i    = v.rd;
        lat     = (EarlyOut && v.early) ? 1 : v.n + 2;
        sb.push_back('{res: v.exp, rd: v.rd, cyc: cyc + lat});
        #1;
        check("stall_accept", 64'(stall_req_o), 64'(1));
        @(posedge clock);
        #1;
        valid_i  = 1'b0;
        got      = 1'b0;
        stall_hi = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (done_o) begin
                got = 1'b1;
                check("stall_in_done", 64'(stall_req_o), 64'(0));
            end else if (stall_req_o) begin
                stall_hi++;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout [%s]: no done_o within 200 cycles, required one", cur);
            sb.delete();
        end else begin
            check("stall_cycles", 64'(stall_hi), 64'(lat - 1));
        end
    endtask

    task automatic add(input string name, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input logic [4:0] rd,
                       input int n, input bit early);
        vecs.push_back('{name: name, op: op, a: a, b: b, exp: exp, rd: rd, n: n, early: early});
    endtask

    initial begin
        vec_t v;
        reset   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        op_i    = '0;
        srcA_i  = '0;
        srcB_i  = '0;
        rd_i    = '0;

        add("mul_3x-5", MD_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 5'd1, 64, 0);
        add("mulh_m1", MD_MULH, '1, '1, 64'h0, 5'd2, 64, 0);
        add("mulhu_m1", MD_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 5'd3, 64, 0);
        add("mulhsu_m1", MD_MULHSU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 64, 0);
        add("div_by0", MD_DIV, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64, 1);
        add("rem_by0", MD_REM, 64'd7, 64'd0, 64'd7, 5'd6, 64, 1);
        add("div_ovf", MD_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000,
            5'd7, 64, 1);
        add("rem_ovf", MD_REM, 64'h8000_0000_0000_0000, '1, 64'd0, 5'd8, 64, 1);
        add("divw", MD_DIVW, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002,
            64'hFFFF_FFFF_FFFF_FFFD, 5'd9, 32, 0);
        add("divu", MD_DIVU, 64'd100, 64'd7, 64'd14, 5'd10, 64, 0);
        add("remu", MD_REMU, 64'd100, 64'd7, 64'd2, 5'd11, 64, 0);
        add("div_neg", MD_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2,
            5'd12, 64, 0);
        add("rem_neg", MD_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
            5'd13, 64, 0);
        add("mulw", MD_MULW, 64'hAAAA_AAAA_7FFF_FFFF, 64'h5555_5555_0000_0002,
            64'hFFFF_FFFF_FFFF_FFFE, 5'd14, 32, 0);
        add("remuw_by0", MD_REMUW, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000,
            64'hFFFF_FFFF_8000_0001, 5'd15, 32, 1);
        add("divuw_by0", MD_DIVUW, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 32, 1);
        add("divw_ovf", MD_DIVW, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 5'd17, 32, 1);
        add("remw_ovf", MD_REMW, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'd0, 5'd18, 32, 1);
        add("mul_zero", MD_MUL, 64'd0, 64'd5, 64'd0, 5'd19, 64, 1);

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("reset_result", result_o, 64'd0);
        check("reset_rd", 64'(rd_o), 64'd0);
        check("reset_done", 64'(done_o), 64'd0);
        check("reset_stall", 64'(stall_req_o), 64'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset in the middle of a multiply.
        cur = "reset_mid_op";
        @(posedge clock);
        #1;
        valid_i = 1'b1;
        op_i    = MD_MUL;
        srcA_i  = 64'd9;
        srcB_i  = 64'd9;
        rd_i    = 5'd20;
        @(posedge clock);
        #1;
        valid_i = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_stall", 64'(stall_req_o), 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        check("rst_mid_rd", 64'(rd_o), 64'd0);
        repeat (70) @(posedge clock);

        v = '{name: "mul_11x13", op: MD_MUL, a: 64'd11, b: 64'd13, exp: 64'd143, rd: 5'd9,
              n: 64, early: 0};
        run_op(v);

        // Flush a divide in cycle 10; the unit must be idle in cycle 11.
        cur = "flush_div";
        @(posedge clock);
        #1;
        valid_i = 1'b1;
        op_i    = MD_DIV;
        srcA_i  = 64'd100;
        srcB_i  = 64'd7;
        rd_i    = 5'd21;
        @(posedge clock);
        #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        flush_i = 1'b1;
        #1;
        check("flush_stall_busy", 64'(stall_req_o), 64'd1);
        @(posedge clock);
        #1;
        flush_i = 1'b0;
        #1;
        check("flush_idle_stall", 64'(stall_req_o), 64'd0);
        check("flush_keep_result", result_o, 64'd143);
        check("flush_keep_rd", 64'(rd_o), 64'd9);
        v = '{name: "mul_6x7", op: MD_MUL, a: 64'd6, b: 64'd7, exp: 64'd42, rd: 5'd10,
              n: 64, early: 0};
        run_op(v);

        // valid_i together with flush_i in IDLE must not accept.
        cur = "flush_valid_idle";
        @(posedge clock);
        #1;
        valid_i = 1'b1;
        flush_i = 1'b1;
        op_i    = MD_MUL;
        srcA_i  = 64'd2;
        srcB_i  = 64'd2;
        rd_i    = 5'd22;
        #1;
        check("flush_valid_stall", 64'(stall_req_o), 64'd0);
        @(posedge clock);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        #1;
        check("flush_valid_noacc", 64'(stall_req_o), 64'd0);
        repeat (70) @(posedge clock);
        check("flush_valid_result", result_o, 64'd42);

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL leftover [%s]: %0d expectations unconsumed, required 0", cur, sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
